mvb_loopback_checker: RTL and testbench
=======================================

MVB_LOOPBACK_CHECKER -- requirements
Module: mvb_loopback_checker

Interface
REQ-001 Parameter DATA_W, default 16, width of one MVB data word.
REQ-002 Parameter MAX_WORDS, default 16, maximum words per frame and capture-store depth (power of two).
REQ-003 Parameter PAT_STEP, default 16'h1111, increment used by incrementing pattern mode.
REQ-004 Parameter RX_TIMEOUT, default 65535, clk cycles allowed between send and rx_frame_over.
REQ-005 Parameter GAP_CYC, default 1000, idle clk cycles between consecutive frames.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle pulse; begins a test run; ignored while busy=1.
REQ-009 stop  input  1  level; run ends after the current frame completes.
REQ-010 mode  input  2  pattern: 0 incrementing, 1 walking-one, 2 LFSR, 3 constant seed; sampled at start.
REQ-011 seed  input  DATA_W  first word of every frame; sampled at start.
REQ-012 n_words  input  $clog2(MAX_WORDS)+1  words per frame, 1..MAX_WORDS; sampled at start.
REQ-013 n_frames  input  8  frames per run; 0 = continuous until stop; sampled at start.
REQ-014 tx_data / tx_wr_en  output  DATA_W / 1  encoder FIFO write word and strobe.
REQ-015 tx_send  output  1  one-cycle frame-send pulse to encoder.
REQ-016 tx_frame_over  input  1  encoder end-of-transmission pulse.
REQ-017 rx_frame_over  input  1  decoder end-of-frame pulse.
REQ-018 rx_err  input  5  decoder flags {length, signal, delimiter, quality, crc}, valid with rx_frame_over.
REQ-019 rx_rd_en / rx_data  output 1 / input DATA_W  decoder FIFO read strobe; data valid exactly 1 cycle after rd_en.
REQ-020 busy, done  output  1 each  run active; one-cycle pulse at run end.
REQ-021 pass_cnt, fail_cnt, word_err_cnt  output  16 each  saturating counters.
REQ-022 err_flags  output  6  sticky {timeout, rx_err[4:0]} OR'd over the run.
REQ-023 disp_idx / disp_data  input $clog2(MAX_WORDS) / output DATA_W  combinational read of last captured frame.

Function
REQ-024 States: IDLE, FILL, SEND, WAIT_RX, READ, GAP, FIN; IDLE->FILL on start.
REQ-025 FILL: tx_wr_en=1 for exactly n_words consecutive cycles, tx_data = pattern word k (k=0..n_words-1), then SEND.
REQ-026 Pattern word 0 = seed; mode0 next = prev+PAT_STEP mod 2^DATA_W; mode1 next = rotate-left-1; mode2 next = Fibonacci LFSR x^16+x^14+x^13+x^11+1 shift-left; mode3 next = prev.
REQ-027 SEND: tx_send=1 for one cycle, then WAIT_RX with timeout counter cleared.
REQ-028 WAIT_RX: on rx_frame_over latch rx_err, go READ; at RX_TIMEOUT cycles set err_flags[5], count frame fail, go GAP.
REQ-029 READ: rx_rd_en=1 for n_words cycles; each returned word k written to capture store[k] and compared with regenerated pattern word k; each mismatch increments word_err_cnt.
REQ-030 Frame passes iff zero mismatches and latched rx_err==0; pass_cnt or fail_cnt increments once per frame in the cycle after last word compared.
REQ-031 GAP: count GAP_CYC cycles, then FILL, unless frames done (n_frames reached, n_frames!=0) or stop=1, then FIN.
REQ-032 FIN: done=1 one cycle, busy=0, go IDLE; counters and err_flags hold until next start.
REQ-033 start in IDLE clears all counters, err_flags, frame counter; capture store not cleared.
REQ-034 Counters saturate at 16'hFFFF, no wrap.
REQ-035 rx_frame_over outside WAIT_RX ignored; tx_frame_over informational only, not required for progress.
REQ-036 stop asserted during FILL/SEND/WAIT_RX/READ takes effect only at GAP exit.

Reset
REQ-037 rst forces IDLE; tx_wr_en, tx_send, rx_rd_en, busy, done = 0; tx_data = 0; all counters and err_flags = 0.
REQ-038 rst mid-frame abandons the frame with no counter update; capture store contents undefined.

Structure
REQ-039 Shared package mvb_pkg holds state enum, mode encodings, rx_err bit indices, LFSR taps.
REQ-040 Pattern generator is sub-module mvb_pattern_gen (load seed, advance, word out), instantiated twice: TX and compare.

Verification
REQ-041 Ideal loopback, mode0, seed 0, n_words 16, n_frames 3 -> words 0000,1111..FFFF; pass_cnt 3, fail_cnt 0, done pulse.
REQ-042 rx_data bit0 flipped on word 5 of frame 2, n_frames 4 -> word_err_cnt 1, fail_cnt 1, pass_cnt 3.
REQ-043 rx_err=5'b00001 with frame_over, data correct -> fail_cnt 1, err_flags 6'b000001.
REQ-044 No rx_frame_over, RX_TIMEOUT 100 -> fail after 100 cycles, err_flags[5]=1, next frame starts after GAP.
REQ-045 n_frames 0, stop raised during READ of frame 5 -> frame 5 counted, FIN, pass_cnt 5.
REQ-046 rst asserted in READ -> next cycle all outputs zero, state IDLE; new start runs normally.

Source files
------------

// File: rtl/mvb_loopback_checker_pkg.sv
// Shared types and constants for the MVB loopback checker and its pattern generators.
package mvb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SEND,
    ST_WAIT_RX,
    ST_READ,
    ST_GAP,
    ST_FIN
  } state_t;

  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_WALK  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_CONST = 2'd3
  } mode_t;

  // Bit positions inside err_flags; the low five mirror the decoder rx_err vector.
  localparam int ERR_CRC     = 0;
  localparam int ERR_QUALITY = 1;
  localparam int ERR_DELIM   = 2;
  localparam int ERR_SIGNAL  = 3;
  localparam int ERR_LENGTH  = 4;
  localparam int ERR_TIMEOUT = 5;

  // Feedback taps of x^16+x^14+x^13+x^11+1 as bit indices of a left-shifting register.
  localparam int LFSR_TAP0 = 15;
  localparam int LFSR_TAP1 = 13;
  localparam int LFSR_TAP2 = 12;
  localparam int LFSR_TAP3 = 10;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mvb_loopback_checker_if.sv
// Encoder/decoder side of the loopback checker: TX FIFO fill, send pulse, RX FIFO drain.
interface mvb_loopback_checker_if #(
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_wr_en;
  logic              tx_send;
  logic              tx_frame_over;
  logic              rx_frame_over;
  logic [4:0]        rx_err;
  logic              rx_rd_en;
  logic [DATA_W-1:0] rx_data;

  modport master (
    output tx_data, tx_wr_en, tx_send, rx_rd_en,
    input  tx_frame_over, rx_frame_over, rx_err, rx_data
  );

  modport slave (
    input  tx_data, tx_wr_en, tx_send, rx_rd_en,
    output tx_frame_over, rx_frame_over, rx_err, rx_data
  );

endinterface

// File: rtl/mvb_loopback_checker_pattern_gen.sv
// Test-pattern word generator: load a seed, then step through the selected sequence on advance.
module mvb_pattern_gen
  import mvb_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] PAT_STEP = 16'h1111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  mode_t             mode,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] word
);

  logic [DATA_W-1:0] next_word;

  always_comb begin
    next_word = word;
    case (mode)
      MODE_INC:  next_word = word + PAT_STEP;
      MODE_WALK: next_word = {word[DATA_W-2:0], word[DATA_W-1]};
      MODE_LFSR: next_word = {word[DATA_W-2:0],
                              word[LFSR_TAP0] ^ word[LFSR_TAP1] ^ word[LFSR_TAP2] ^ word[LFSR_TAP3]};
      default:   next_word = word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
    end else if (load) begin
      word <= seed;
    end else if (advance) begin
      word <= next_word;
    end
  end

endmodule

// File: rtl/mvb_loopback_checker.sv
// Loopback checker: fills the encoder with a pattern frame, sends it, drains the decoder
// and compares every returned word against a second, identically seeded pattern generator.
module mvb_loopback_checker
  import mvb_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                MAX_WORDS  = 16,
  parameter logic [DATA_W-1:0] PAT_STEP   = 16'h1111,
  parameter int                RX_TIMEOUT = 65535,
  parameter int                GAP_CYC    = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic [1:0]                   mode,
  input  logic [DATA_W-1:0]            seed,
  input  logic [$clog2(MAX_WORDS):0]   n_words,
  input  logic [7:0]                   n_frames,
  mvb_loopback_checker_if.master       bus,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  pass_cnt,
  output logic [15:0]                  fail_cnt,
  output logic [15:0]                  word_err_cnt,
  output logic [5:0]                   err_flags,
  input  logic [$clog2(MAX_WORDS)-1:0] disp_idx,
  output logic [DATA_W-1:0]            disp_data
);

  localparam int IDX_W = $clog2(MAX_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam int TO_W  = $clog2(RX_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  state_t            state;
  mode_t             mode_q;
  logic [DATA_W-1:0] seed_q;
  logic [CNT_W-1:0]  n_words_q;
  logic [7:0]        n_frames_q;
  logic [7:0]        frame_cnt;
  logic [CNT_W-1:0]  k_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  cmp_idx;
  logic              rd_val;
  logic              verdict_pend;
  logic              frame_bad;
  logic [4:0]        rx_err_q;
  logic [TO_W-1:0]   tout_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [DATA_W-1:0] store [MAX_WORDS];

  logic [DATA_W-1:0] tx_word, rx_word, gen_seed;
  logic [CNT_W-1:0]  last_idx;
  logic              gap_done, run_over, gen_load, rx_compare, word_miss;

  assign last_idx   = n_words_q - CNT_W'(1);
  assign gap_done   = (gap_cnt == GAP_W'(GAP_CYC - 1));
  assign run_over   = stop || ((n_frames_q != 8'd0) && (frame_cnt == n_frames_q));
  assign gen_seed   = (state == ST_IDLE) ? seed : seed_q;
  assign gen_load   = ((state == ST_IDLE) && start) || ((state == ST_GAP) && gap_done && !run_over);
  // Returned data is valid the cycle after rx_rd_en was seen by the decoder.
  assign rx_compare = (state == ST_READ) && rd_val;
  assign word_miss  = (bus.rx_data != rx_word);
  assign disp_data  = store[disp_idx];

  mvb_pattern_gen #(.DATA_W(DATA_W), .PAT_STEP(PAT_STEP)) u_tx_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (gen_load),
    .advance (state == ST_FILL),
    .mode    (mode_q),
    .seed    (gen_seed),
    .word    (tx_word)
  );

  mvb_pattern_gen #(.DATA_W(DATA_W), .PAT_STEP(PAT_STEP)) u_cmp_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (gen_load),
    .advance (rx_compare),
    .mode    (mode_q),
    .seed    (gen_seed),
    .word    (rx_word)
  );

  always_ff @(posedge clk) begin
    if (rx_compare) begin
      store[cmp_idx[IDX_W-1:0]] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bus.tx_data  <= '0;
      bus.tx_wr_en <= 1'b0;
      bus.tx_send  <= 1'b0;
      bus.rx_rd_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      word_err_cnt <= '0;
      err_flags    <= '0;
      mode_q       <= MODE_INC;
      seed_q       <= '0;
      n_words_q    <= '0;
      n_frames_q   <= '0;
      frame_cnt    <= '0;
      k_cnt        <= '0;
      rd_cnt       <= '0;
      cmp_idx      <= '0;
      rd_val       <= 1'b0;
      verdict_pend <= 1'b0;
      frame_bad    <= 1'b0;
      rx_err_q     <= '0;
      tout_cnt     <= '0;
      gap_cnt      <= '0;
    end else begin
      done         <= 1'b0;
      bus.tx_wr_en <= 1'b0;
      bus.tx_send  <= 1'b0;
      bus.rx_rd_en <= 1'b0;
      rd_val       <= bus.rx_rd_en;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q       <= mode_t'(mode);
            seed_q       <= seed;
            n_words_q    <= n_words;
            n_frames_q   <= n_frames;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            word_err_cnt <= '0;
            err_flags    <= '0;
            frame_cnt    <= '0;
            k_cnt        <= '0;
            busy         <= 1'b1;
            state        <= ST_FILL;
          end
        end
        ST_FILL: begin
          bus.tx_wr_en <= 1'b1;
          bus.tx_data  <= tx_word;
          k_cnt        <= k_cnt + CNT_W'(1);
          if (k_cnt == last_idx) begin
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          bus.tx_send <= 1'b1;
          tout_cnt    <= '0;
          state       <= ST_WAIT_RX;
        end
        ST_WAIT_RX: begin
          if (bus.rx_frame_over) begin
            rx_err_q     <= bus.rx_err;
            err_flags    <= err_flags | {1'b0, bus.rx_err};
            rd_cnt       <= '0;
            cmp_idx      <= '0;
            frame_bad    <= 1'b0;
            verdict_pend <= 1'b0;
            state        <= ST_READ;
          end else if (tout_cnt == TO_W'(RX_TIMEOUT - 1)) begin
            err_flags[ERR_TIMEOUT] <= 1'b1;
            fail_cnt               <= sat_inc(fail_cnt);
            frame_cnt              <= frame_cnt + 8'd1;
            gap_cnt                <= '0;
            state                  <= ST_GAP;
          end else begin
            tout_cnt <= tout_cnt + TO_W'(1);
          end
        end
        ST_READ: begin
          if (rd_cnt < n_words_q) begin
            bus.rx_rd_en <= 1'b1;
            rd_cnt       <= rd_cnt + CNT_W'(1);
          end
          if (rd_val) begin
            if (word_miss) begin
              word_err_cnt <= sat_inc(word_err_cnt);
              frame_bad    <= 1'b1;
            end
            cmp_idx <= cmp_idx + CNT_W'(1);
            if (cmp_idx == last_idx) begin
              verdict_pend <= 1'b1;
            end
          end
          // Verdict lands one cycle after the last compare so its mismatch is included.
          if (verdict_pend) begin
            if (frame_bad || (rx_err_q != 5'd0)) begin
              fail_cnt <= sat_inc(fail_cnt);
            end else begin
              pass_cnt <= sat_inc(pass_cnt);
            end
            verdict_pend <= 1'b0;
            frame_cnt    <= frame_cnt + 8'd1;
            gap_cnt      <= '0;
            state        <= ST_GAP;
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + GAP_W'(1);
          if (gap_done) begin
            if (run_over) begin
              state <= ST_FIN;
            end else begin
              k_cnt <= '0;
              state <= ST_FILL;
            end
          end
        end
        ST_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvb_loopback_checker.sv
// Randomized bench for mvb_loopback_checker: an encoder/decoder loopback model with per-frame
// fault plans, and run-level expectations computed from the pattern rules.
module tb_mvb_loopback_checker;

  localparam int DATA_W = 16;
  localparam int RX_TO  = 100;
  localparam int GAP    = 20;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [1:0]  mode;
  logic [15:0] seed;
  logic [4:0]  n_words;
  logic [7:0]  n_frames;
  logic        busy, done;
  logic [15:0] pass_cnt, fail_cnt, word_err_cnt;
  logic [5:0]  err_flags;
  logic [3:0]  disp_idx;
  logic [15:0] disp_data;

  int compCount = 0;
  int failCount = 0;

  mvb_loopback_checker_if #(.DATA_W(DATA_W)) bus ();

  mvb_loopback_checker #(
    .DATA_W(DATA_W), .MAX_WORDS(16), .PAT_STEP(16'h1111), .RX_TIMEOUT(RX_TO), .GAP_CYC(GAP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .seed(seed),
    .n_words(n_words), .n_frames(n_frames), .bus(bus), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .word_err_cnt(word_err_cnt),
    .err_flags(err_flags), .disp_idx(disp_idx), .disp_data(disp_data)
  );

  always #5 clk = ~clk;

  // Per-frame fault plan and run settings shared with the loopback model
  bit          planTimeout [16];
  logic [4:0]  planErr     [16];
  int          planBad     [16];
  logic [15:0] planMask    [16];
  bit          planSpur    [16];
  int          runMode, runWords;
  logic [15:0] runSeed;

  logic [15:0] rxQ [$];
  int          txIdx, sendCount, countdown, cyc;
  int          sendCyc [16];
  int          fillCyc [16];
  logic [4:0]  pendErr;
  bit          pendValid, prevBusy;
  logic [15:0] pendWord;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] patWord(input int m, input logic [15:0] s, input int k);
    logic [15:0] w;
    w = s;
    if (m == 0) return s + 16'(k * 32'h1111);
    for (int i = 0; i < k; i++) begin
      if (m == 1) w = (w << 1) | (w >> 15);
      else if (m == 2) w = (w << 1) | {15'd0, w[15] ^ w[13] ^ w[12] ^ w[10]};
    end
    return w;
  endfunction

  task automatic clearPlan();
    for (int f = 0; f < 16; f++) begin
      planTimeout[f] = 1'b0;
      planErr[f]     = 5'd0;
      planBad[f]     = -1;
      planMask[f]    = 16'h0;
      planSpur[f]    = 1'b0;
    end
  endtask

  // Encoder/decoder loopback model, driven on falling edges
  initial begin
    bus.tx_frame_over = 1'b0; bus.rx_frame_over = 1'b0; bus.rx_err = 5'd0; bus.rx_data = 16'd0;
    txIdx = 0; sendCount = 0; countdown = 0; cyc = 0; pendValid = 1'b0; prevBusy = 1'b0;
    pendErr = 5'd0; pendWord = 16'd0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.tx_frame_over = 1'b0; bus.rx_frame_over = 1'b0; bus.rx_err = 5'd0;
      if (rst) begin
        rxQ.delete();
        txIdx = 0; sendCount = 0; countdown = 0; pendValid = 1'b0; prevBusy = 1'b0;
        bus.rx_data = 16'd0;
      end else begin
        if (busy && !prevBusy) begin
          txIdx = 0; sendCount = 0;
        end
        prevBusy = busy;
        bus.rx_data = pendValid ? pendWord : 16'($urandom);
        pendValid = bus.rx_rd_en;
        if (bus.rx_rd_en) begin
          if (rxQ.size() > 0) pendWord = rxQ.pop_front();
          else begin
            checkOutput("rd_underflow", 32'd1, 32'd0);
            pendWord = 16'($urandom);
          end
        end
        if (bus.tx_wr_en) begin
          if (txIdx == 0 && sendCount < 16) begin
            fillCyc[sendCount] = cyc;
            if (planSpur[sendCount]) begin
              bus.rx_frame_over = 1'b1; bus.rx_err = 5'h1F;
            end
          end
          checkOutput("tx_word", 32'(bus.tx_data), 32'(patWord(runMode, runSeed, txIdx)));
          txIdx++;
        end
        if (bus.tx_send) begin
          checkOutput("tx_len", txIdx, runWords);
          txIdx = 0;
          bus.tx_frame_over = 1'b1;
          if (sendCount < 16) begin
            sendCyc[sendCount] = cyc;
            if (!planTimeout[sendCount]) begin
              for (int k = 0; k < runWords; k++)
                rxQ.push_back(patWord(runMode, runSeed, k) ^
                              ((k == planBad[sendCount]) ? planMask[sendCount] : 16'h0));
              pendErr   = planErr[sendCount];
              countdown = 2 + $urandom_range(0, 6);
            end
          end
          sendCount++;
        end else if (countdown > 0) begin
          countdown--;
          if (countdown == 0) begin
            bus.rx_frame_over = 1'b1; bus.rx_err = pendErr;
          end
        end
      end
    end
  end

  task automatic checkIdleZero(input string pfx);
    checkOutput({pfx, "_busy"}, 32'(busy), 32'd0);
    checkOutput({pfx, "_done"}, 32'(done), 32'd0);
    checkOutput({pfx, "_wr_en"}, 32'(bus.tx_wr_en), 32'd0);
    checkOutput({pfx, "_send"}, 32'(bus.tx_send), 32'd0);
    checkOutput({pfx, "_rd_en"}, 32'(bus.rx_rd_en), 32'd0);
    checkOutput({pfx, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    checkOutput({pfx, "_counters"}, {pass_cnt, fail_cnt | word_err_cnt}, 32'd0);
    checkOutput({pfx, "_err_flags"}, 32'(err_flags), 32'd0);
  endtask

  task automatic applyStimulus(input int m, input logic [15:0] s, input int nw, input int nf,
                               input int stopFrame);
    bit ok;
    runMode = m; runSeed = s; runWords = nw;
    @(negedge clk);
    mode = 2'(m); seed = s; n_words = 5'(nw); n_frames = 8'(nf); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = 2'($urandom); seed = 16'($urandom); n_words = 5'($urandom_range(1, 16));
    n_frames = 8'($urandom_range(1, 9));
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (stopFrame >= 0 && sendCount == stopFrame + 1 && bus.rx_rd_en) stop = 1'b1;
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    stop = 1'b0;
    checkOutput("done_seen", 32'(ok), 32'd1);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    if (!ok) begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic checkRun(input int nw, input int frames);
    int expPass = 0, expFail = 0, expWerr = 0;
    logic [5:0] expFlags = 6'd0;
    bit bad;
    for (int f = 0; f < frames; f++) begin
      if (planTimeout[f]) begin
        expFail++; expFlags[5] = 1'b1;
      end else begin
        bad = (planBad[f] >= 0) && (planBad[f] < nw);
        if (bad) expWerr++;
        if (bad || planErr[f] != 5'd0) expFail++; else expPass++;
        expFlags = expFlags | {1'b0, planErr[f]};
      end
    end
    checkOutput("pass_cnt", 32'(pass_cnt), expPass);
    checkOutput("fail_cnt", 32'(fail_cnt), expFail);
    checkOutput("word_err_cnt", 32'(word_err_cnt), expWerr);
    checkOutput("err_flags", 32'(err_flags), 32'(expFlags));
    checkOutput("frames_sent", sendCount, frames);
    checkOutput("rx_fifo_left", rxQ.size(), 0);
    if (!planTimeout[frames-1]) begin
      for (int k = 0; k < nw; k++) begin
        disp_idx = 4'(k);
        #1;
        checkOutput("capture", 32'(disp_data),
                    32'(patWord(runMode, runSeed, k) ^ ((k == planBad[frames-1]) ? planMask[frames-1] : 16'h0)));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int m, nw, nf, gapDiff;
    bit reached;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; seed = 16'd0;
    n_words = 5'd1; n_frames = 8'd1; disp_idx = 4'd0;
    clearPlan();
    runMode = 0; runSeed = 16'd0; runWords = 1;
    repeat (3) @(negedge clk);
    checkIdleZero("reset");
    rst = 1'b0;

    $display("[TB] ideal loopback, incrementing from 0, 3 frames");
    clearPlan();
    applyStimulus(0, 16'h0000, 16, 3, -1);
    checkRun(16, 3);

    $display("[TB] bit flip on word 5 of frame 2");
    clearPlan();
    planBad[1] = 5; planMask[1] = 16'h0001;
    applyStimulus(0, 16'h0000, 16, 4, -1);
    checkRun(16, 4);

    $display("[TB] decoder crc flag with clean data");
    clearPlan();
    planErr[0] = 5'b00001;
    applyStimulus(2, 16'hACE1, 8, 1, -1);
    checkRun(8, 1);

    $display("[TB] missing frame_over then recovery");
    clearPlan();
    planTimeout[0] = 1'b1;
    applyStimulus(1, 16'h0001, 4, 2, -1);
    checkRun(4, 2);
    gapDiff = fillCyc[1] - sendCyc[0];
    checkOutput("timeout_gap_window", 32'(gapDiff >= RX_TO + GAP && gapDiff <= RX_TO + GAP + 4), 32'd1);

    $display("[TB] continuous run stopped during frame 5 readout");
    clearPlan();
    planSpur[1] = 1'b1;
    applyStimulus(3, 16'h5A5A, 8, 0, 4);
    checkRun(8, 5);

    $display("[TB] reset during readout");
    clearPlan();
    runMode = 0; runSeed = 16'h0100; runWords = 6;
    @(negedge clk);
    mode = 2'd0; seed = 16'h0100; n_words = 5'd6; n_frames = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (sendCount == 2 && bus.rx_rd_en) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("reach_read", 32'(reached), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkIdleZero("mid_read_reset");
    @(negedge clk);
    rst = 1'b0;
    clearPlan();
    applyStimulus(0, 16'h0100, 6, 2, -1);
    checkRun(6, 2);

    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      clearPlan();
      m  = $urandom_range(0, 3);
      nw = (r == 0) ? 1 : (r == 1) ? 16 : $urandom_range(1, 16);
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        planTimeout[f] = ($urandom_range(0, 5) == 0);
        planErr[f]     = ($urandom_range(0, 1) == 1) ? 5'd0 : 5'($urandom_range(1, 31));
        if ($urandom_range(0, 2) == 0) begin
          planBad[f]  = $urandom_range(0, nw - 1);
          planMask[f] = 16'($urandom_range(1, 65535));
        end
        planSpur[f] = 1'($urandom_range(0, 1));
      end
      applyStimulus(m, 16'($urandom), nw, nf, -1);
      checkRun(nw, nf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
